// File: rtl/dcache_assoc.sv
// Set-associative write-back, write-allocate data cache with a single outstanding access.
// Optional statistics counters are enabled with DCACHE_ASSOC_STATS_EN.

package dcache_assoc_pkg;
    typedef enum logic [1:0] {
        SIZE_8  = 2'd0,
        SIZE_16 = 2'd1,
        SIZE_32 = 2'd2,
        SIZE_64 = 2'd3
    } dcache_data_size_e;
endpackage

// state       | meaning
// S_IDLE      | ready for a new request
// S_LOOKUP    | tag compare, respond on hit (first lookup or replay)
// S_WB        | writing back the dirty victim line
// S_FILL_REQ  | issuing the refill read
// S_FILL_WAIT | waiting for refill data
module dcache_assoc
    import dcache_assoc_pkg::*;
#(
    parameter int addr_width      = 16,
    parameter int line_width      = 64,
    parameter int sets            = 16,
    parameter int ways            = 2,
    parameter int line_addr_width = addr_width - $clog2(line_width / 8)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_write_i,
    input  logic [addr_width-1:0]      addr_i,
    input  dcache_data_size_e          size_i,
    input  logic [63:0]                wdata_i,
    output logic                       resp_valid_o,
    output logic [63:0]                rdata_o,
    output logic                       hit_o,
    output logic                       mem_req_valid_o,
    input  logic                       mem_req_ready_i,
    output logic                       mem_req_write_o,
    output logic [line_addr_width-1:0] mem_addr_o,
    output logic [line_width-1:0]      mem_wdata_o,
    input  logic                       mem_resp_valid_i,
    input  logic [line_width-1:0]      mem_rdata_i
`ifdef DCACHE_ASSOC_STATS_EN
    ,
    output logic [31:0]                hit_count_o,
    output logic [31:0]                miss_count_o,
    output logic [31:0]                wb_count_o
`endif
);

    localparam int off_w  = $clog2(line_width / 8);
    localparam int set_w  = $clog2(sets);
    localparam int tag_w  = addr_width - off_w - set_w;
    localparam int way_w  = (ways > 1) ? $clog2(ways) : 1;
    localparam int words  = line_width / 64;
    localparam int word_w = (words > 1) ? $clog2(words) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB,
        S_FILL_REQ,
        S_FILL_WAIT
    } state_e;

    state_e state_q, state_d;

    logic                  req_write_q;
    logic [addr_width-1:0] addr_q;
    dcache_data_size_e     size_q;
    logic [63:0]           wdata_q;
    logic                  replay_q;
    logic [way_w-1:0]      victim_way_q;
    logic                  victim_valid_q;

    logic [line_width-1:0] data_q  [sets][ways];
    logic [tag_w-1:0]      tag_q   [sets][ways];
    logic [ways-1:0]       valid_q [sets];
    logic [ways-1:0]       dirty_q [sets];
    logic [way_w-1:0]      rr_q    [sets];

    logic [off_w-1:0]  req_off;
    logic [set_w-1:0]  set_idx;
    logic [tag_w-1:0]  req_tag;
    logic [word_w-1:0] word_idx;
    logic [2:0]        byte_off;
    logic [5:0]        shamt;
    logic [63:0]       size_mask;

    assign req_off  = addr_q[off_w-1:0];
    assign set_idx  = addr_q[off_w +: set_w];
    assign req_tag  = addr_q[off_w + set_w +: tag_w];
    assign word_idx = word_w'(req_off >> 3);
    assign shamt    = {byte_off, 3'b000};

    // Low offset bits below the access size are dropped to force natural alignment.
    always_comb begin
        byte_off  = 3'b000;
        size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        case (size_q)
            SIZE_8: begin
                byte_off  = req_off[2:0];
                size_mask = 64'h0000_0000_0000_00FF;
            end
            SIZE_16: begin
                byte_off  = {req_off[2:1], 1'b0};
                size_mask = 64'h0000_0000_0000_FFFF;
            end
            SIZE_32: begin
                byte_off  = {req_off[2], 2'b00};
                size_mask = 64'h0000_0000_FFFF_FFFF;
            end
            default: begin
                byte_off  = 3'b000;
                size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
            end
        endcase
    end

    logic             hit;
    logic [way_w-1:0] hit_way;
    logic             found_invalid;
    logic [way_w-1:0] victim_way;
    logic             victim_valid;
    logic             victim_dirty;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < ways; w++) begin
            if (!hit && valid_q[set_idx][w] && (tag_q[set_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = way_w'(w);
            end
        end
    end

    always_comb begin
        found_invalid = 1'b0;
        victim_way    = rr_q[set_idx];
        for (int w = 0; w < ways; w++) begin
            if (!found_invalid && !valid_q[set_idx][w]) begin
                found_invalid = 1'b1;
                victim_way    = way_w'(w);
            end
        end
    end

    assign victim_valid = valid_q[set_idx][victim_way];
    assign victim_dirty = dirty_q[set_idx][victim_way];

    logic [line_width-1:0] hit_line;
    logic [line_width-1:0] store_line;
    logic [63:0]           hit_word;
    logic [63:0]           load_data;
    logic [63:0]           merged_word;

    always_comb begin
        hit_line    = data_q[set_idx][hit_way];
        hit_word    = hit_line[word_idx*64 +: 64];
        load_data   = (hit_word >> shamt) & size_mask;
        merged_word = (hit_word & ~(size_mask << shamt)) | ((wdata_q & size_mask) << shamt);
        store_line  = hit_line;
        store_line[word_idx*64 +: 64] = merged_word;
    end

    logic accept;
    logic st_wr_en;
    logic fill_en;
    logic victim_ld;

    always_comb begin
        state_d         = state_q;
        req_ready_o     = 1'b0;
        resp_valid_o    = 1'b0;
        rdata_o         = '0;
        hit_o           = 1'b0;
        mem_req_valid_o = 1'b0;
        mem_req_write_o = 1'b0;
        mem_addr_o      = '0;
        mem_wdata_o     = '0;
        accept          = 1'b0;
        st_wr_en        = 1'b0;
        fill_en         = 1'b0;
        victim_ld       = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    accept  = 1'b1;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    resp_valid_o = 1'b1;
                    hit_o        = !replay_q;
                    if (req_write_q) begin
                        st_wr_en = 1'b1;
                    end else begin
                        rdata_o = load_data;
                    end
                    state_d = S_IDLE;
                end else begin
                    victim_ld = 1'b1;
                    state_d   = (victim_valid && victim_dirty) ? S_WB : S_FILL_REQ;
                end
            end
            S_WB: begin
                mem_req_valid_o = 1'b1;
                mem_req_write_o = 1'b1;
                mem_addr_o      = {tag_q[set_idx][victim_way_q], set_idx};
                mem_wdata_o     = data_q[set_idx][victim_way_q];
                if (mem_req_ready_i) begin
                    state_d = S_FILL_REQ;
                end
            end
            S_FILL_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_addr_o      = addr_q[addr_width-1:off_w];
                if (mem_req_ready_i) begin
                    state_d = S_FILL_WAIT;
                end
            end
            S_FILL_WAIT: begin
                if (mem_resp_valid_i) begin
                    fill_en = 1'b1;
                    state_d = S_LOOKUP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            req_write_q    <= 1'b0;
            addr_q         <= '0;
            size_q         <= SIZE_8;
            wdata_q        <= '0;
            replay_q       <= 1'b0;
            victim_way_q   <= '0;
            victim_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_write_q <= req_write_i;
                addr_q      <= addr_i;
                size_q      <= size_i;
                wdata_q     <= wdata_i;
                replay_q    <= 1'b0;
            end
            if (victim_ld) begin
                victim_way_q   <= victim_way;
                victim_valid_q <= victim_valid;
            end
            if (fill_en) begin
                replay_q <= 1'b1;
            end
        end
    end

    // The round-robin pointer only moves when a valid line is actually replaced.
    logic [way_w-1:0] rr_next;
    assign rr_next = (rr_q[set_idx] == way_w'(ways - 1)) ? '0 : rr_q[set_idx] + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < sets; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            if (st_wr_en) begin
                dirty_q[set_idx][hit_way] <= 1'b1;
            end
            if (fill_en) begin
                valid_q[set_idx][victim_way_q] <= 1'b1;
                dirty_q[set_idx][victim_way_q] <= 1'b0;
                if (victim_valid_q) begin
                    rr_q[set_idx] <= rr_next;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && st_wr_en) begin
            data_q[set_idx][hit_way] <= store_line;
        end
        if (!rst_i && fill_en) begin
            data_q[set_idx][victim_way_q] <= mem_rdata_i;
            tag_q[set_idx][victim_way_q]  <= req_tag;
        end
    end

`ifdef DCACHE_ASSOC_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;
    logic        first_hit, first_miss, wb_done;

    assign first_hit  = (state_q == S_LOOKUP) && !replay_q && hit;
    assign first_miss = (state_q == S_LOOKUP) && !replay_q && !hit;
    assign wb_done    = (state_q == S_WB) && mem_req_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            if (first_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (first_miss && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
            if (wb_done && (wb_cnt_q != 32'hFFFF_FFFF)) begin
                wb_cnt_q <= wb_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
    assign wb_count_o   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed self-checking bench for dcache_assoc: cold/dirty misses, store merge,
// replacement order, memory backpressure and reset during refill.
module tb_dcache_assoc;
    import dcache_assoc_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [15:0]       addr;
    dcache_data_size_e size;
    logic [63:0]       wdata;
    logic              resp_valid;
    logic [63:0]       rdata;
    logic              hit;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_write;
    logic [12:0]       mem_addr;
    logic [63:0]       mem_wdata;
    logic              mem_resp_valid;
    logic [63:0]       mem_rdata;
`ifdef DCACHE_ASSOC_STATS_EN
    logic [31:0]       hit_count, miss_count, wb_count;
`endif

    int errors = 0;
    int checks = 0;

    dcache_assoc dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_write_i      (req_write),
        .addr_i           (addr),
        .size_i           (size),
        .wdata_i          (wdata),
        .resp_valid_o     (resp_valid),
        .rdata_o          (rdata),
        .hit_o            (hit),
        .mem_req_valid_o  (mem_req_valid),
        .mem_req_ready_i  (mem_req_ready),
        .mem_req_write_o  (mem_req_write),
        .mem_addr_o       (mem_addr),
        .mem_wdata_o      (mem_wdata),
        .mem_resp_valid_i (mem_resp_valid),
        .mem_rdata_i      (mem_rdata)
`ifdef DCACHE_ASSOC_STATS_EN
        ,
        .hit_count_o      (hit_count),
        .miss_count_o     (miss_count),
        .wb_count_o       (wb_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [15:0] a, input dcache_data_size_e sz,
                         input logic [63:0] wd, input string tag);
        req_valid = 1'b1;
        req_write = wr;
        addr      = a;
        size      = sz;
        wdata     = wd;
        chk({tag, "_ready"}, 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        wdata     = 64'hDEAD_BEEF_DEAD_BEEF;
    endtask

    // Expects a response on the cycle after acceptance with hit_o set.
    task automatic hit_access(input logic wr, input logic [15:0] a, input dcache_data_size_e sz,
                              input logic [63:0] wd, input logic [63:0] exp_rd, input string tag);
        issue(wr, a, sz, wd, tag);
        chk({tag, "_resp"}, 64'(resp_valid), 64'd1);
        chk({tag, "_hit"}, 64'(hit), 64'd1);
        chk({tag, "_rdata"}, rdata, exp_rd);
        tick();
    endtask

    // Clean miss with memory always ready: refill read in cycle 2, data in cycle 3, reply in cycle 4.
    task automatic miss_access(input logic wr, input logic [15:0] a, input dcache_data_size_e sz,
                               input logic [63:0] wd, input logic [12:0] exp_laddr,
                               input logic [63:0] fill, input logic [63:0] exp_rd, input string tag);
        issue(wr, a, sz, wd, tag);
        chk({tag, "_c1_noresp"}, 64'(resp_valid), 64'd0);
        tick();
        chk({tag, "_c2_memvalid"}, 64'(mem_req_valid), 64'd1);
        chk({tag, "_c2_memwrite"}, 64'(mem_req_write), 64'd0);
        chk({tag, "_c2_memaddr"}, 64'(mem_addr), 64'(exp_laddr));
        tick();
        mem_resp_valid = 1'b1;
        mem_rdata      = fill;
        chk({tag, "_c3_noresp"}, 64'(resp_valid), 64'd0);
        tick();
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        chk({tag, "_c4_resp"}, 64'(resp_valid), 64'd1);
        chk({tag, "_c4_hit"}, 64'(hit), 64'd0);
        chk({tag, "_c4_rdata"}, rdata, exp_rd);
        tick();
    endtask

    localparam logic [63:0] LINE_A  = 64'h1122_3344_5566_7788;
    localparam logic [63:0] LINE_AS = 64'h1122_3344_AB66_7788;
    localparam logic [63:0] LINE_B  = 64'hA1A2_A3A4_A5A6_A7A8;
    localparam logic [63:0] LINE_C  = 64'hB1B2_B3B4_B5B6_B7B8;
    localparam logic [63:0] LINE_D  = 64'hC1C2_C3C4_C5C6_C7C8;
    localparam logic [63:0] LINE_E  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] LINE_F  = 64'h0F0E_0D0C_0B0A_0908;

    initial begin
        rst            = 1'b1;
        req_valid      = 1'b0;
        req_write      = 1'b0;
        addr           = '0;
        size           = SIZE_8;
        wdata          = '0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_hit", 64'(hit), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_mem_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_mem_write", 64'(mem_req_write), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);

        // Cold 32-bit load miss into set 2
        miss_access(1'b0, 16'h0010, SIZE_32, '0, 13'h0002, LINE_A, 64'h5566_7788, "cold_ld");

        // Byte store hit with junk in unused wdata bits, then full-line readback
        hit_access(1'b1, 16'h0013, SIZE_8, 64'hFFFF_FFFF_FFFF_FFAB, 64'd0, "st8_hit");
        hit_access(1'b0, 16'h0010, SIZE_64, '0, LINE_AS, "ld64_hit");

        // Fill the second way of set 2 (invalid way chosen, clean)
        miss_access(1'b0, 16'h0090, SIZE_64, '0, 13'h0012, LINE_B, LINE_B, "way1_fill");

        // Set 2 full: dirty way 0 is written back before the refill
        issue(1'b0, 16'h0110, SIZE_64, '0, "dirty_ev");
        chk("dirty_ev_c1_noresp", 64'(resp_valid), 64'd0);
        tick();
        chk("dirty_ev_wb_valid", 64'(mem_req_valid), 64'd1);
        chk("dirty_ev_wb_write", 64'(mem_req_write), 64'd1);
        chk("dirty_ev_wb_addr", 64'(mem_addr), 64'h0002);
        chk("dirty_ev_wb_data", mem_wdata, LINE_AS);
        tick();
        chk("dirty_ev_fill_valid", 64'(mem_req_valid), 64'd1);
        chk("dirty_ev_fill_write", 64'(mem_req_write), 64'd0);
        chk("dirty_ev_fill_addr", 64'(mem_addr), 64'h0022);
        tick();
        mem_resp_valid = 1'b1;
        mem_rdata      = LINE_C;
        chk("dirty_ev_c4_noresp", 64'(resp_valid), 64'd0);
        tick();
        mem_resp_valid = 1'b0;
        chk("dirty_ev_c5_resp", 64'(resp_valid), 64'd1);
        chk("dirty_ev_c5_hit", 64'(hit), 64'd0);
        chk("dirty_ev_c5_rdata", rdata, LINE_C);
        tick();

`ifdef DCACHE_ASSOC_STATS_EN
        chk("stats_hit", 64'(hit_count), 64'd2);
        chk("stats_miss", 64'(miss_count), 64'd3);
        chk("stats_wb", 64'(wb_count), 64'd1);
`endif

        // Round-robin now points at way 1: evicts the 0x0090 line, 0x0110 survives
        miss_access(1'b0, 16'h0210, SIZE_64, '0, 13'h0042, LINE_D, LINE_D, "rr_way1");
        hit_access(1'b0, 16'h0110, SIZE_64, '0, LINE_C, "rr_keep_way0");
        miss_access(1'b0, 16'h0090, SIZE_32, '0, 13'h0012, LINE_B, 64'hA5A6_A7A8, "rr_refetch");

        // Refill request held off for 5 cycles; a stray response meanwhile is ignored
        mem_req_ready = 1'b0;
        issue(1'b0, 16'h0018, SIZE_64, '0, "bp");
        tick();
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            mem_resp_valid = (i == 2);
            mem_rdata      = 64'hBAD0_BAD0_BAD0_BAD0;
            chk($sformatf("bp_stall%0d_valid", i), 64'(mem_req_valid), 64'd1);
            chk($sformatf("bp_stall%0d_addr", i), 64'(mem_addr), 64'h0003);
            chk($sformatf("bp_stall%0d_ready", i), 64'(req_ready), 64'd0);
            tick();
        end
        req_valid      = 1'b0;
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b1;
        chk("bp_release_valid", 64'(mem_req_valid), 64'd1);
        chk("bp_release_addr", 64'(mem_addr), 64'h0003);
        tick();
        mem_resp_valid = 1'b1;
        mem_rdata      = LINE_E;
        chk("bp_wait_noresp", 64'(resp_valid), 64'd0);
        tick();
        mem_resp_valid = 1'b0;
        chk("bp_resp", 64'(resp_valid), 64'd1);
        chk("bp_rdata", rdata, LINE_E);
        tick();

        // Misaligned offsets are truncated to the access size
        hit_access(1'b0, 16'h001B, SIZE_16, '0, 64'h0000_89AB, "align16");
        hit_access(1'b0, 16'h001E, SIZE_32, '0, 64'h0123_4567, "align32");

        // Reset while waiting for refill data, then a late response
        issue(1'b0, 16'h0020, SIZE_64, '0, "rst_mid");
        tick();
        tick();
        chk("rst_mid_in_wait", 64'(mem_req_valid), 64'd0);
        rst = 1'b1;
        tick();
        rst            = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'hBAD1_BAD1_BAD1_BAD1;
        chk("rst_mid_noresp", 64'(resp_valid), 64'd0);
        chk("rst_mid_idle", 64'(req_ready), 64'd1);
        chk("rst_mid_memvalid", 64'(mem_req_valid), 64'd0);
        tick();
        mem_resp_valid = 1'b0;
        chk("rst_mid_late_noresp", 64'(resp_valid), 64'd0);
        miss_access(1'b0, 16'h0020, SIZE_64, '0, 13'h0004, LINE_F, LINE_F, "rst_mid_reload");
        miss_access(1'b0, 16'h0018, SIZE_64, '0, 13'h0003, LINE_E, LINE_E, "rst_cleared");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcache_assoc.md
# dcache_assoc

Parametrised set-associative, write-back, write-allocate data cache with a valid/ready request port and a line-granular memory port. It sits between the load/store unit and the memory arbiter. On top of the direct-mapped lookup/eject primitive, it adds:
- N-way associativity with valid bits and round-robin replacement
- an internal refill/writeback state machine
- backpressure on both sides

## Interface
- addr_width, 16: byte address width
- line_width, 64: line width in bits; multiple of 64
- sets, 16: number of sets; power of two
- ways, 2: ways per set; ≥1
- line_addr_width, addr_width-$clog2(line_width/8): line address width (derived)

- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  1  request offered
- req_ready_o  out  1  request accepted when both high
- req_write_i  in  1  1 = store, 0 = load
- addr_i  in  addr_width  byte address
- size_i  in  dcache_data_size_e  access size (8/16/32/64 bits)
- wdata_i  in  64  store data, low bits used per size
- resp_valid_o  out  1  one-cycle pulse, access complete
- rdata_o  out  64  load data, zero-extended; 0 for stores
- hit_o  out  1  with resp_valid_o: access hit on first lookup
- mem_req_valid_o  out  1  memory request
- mem_req_ready_i  in  1  memory accepts request
- mem_req_write_o  out  1  1 = writeback, 0 = refill read
- mem_addr_o  out  line_addr_width  line address
- mem_wdata_o  out  line_width  writeback line data
- mem_resp_valid_i  in  1  refill data valid
- mem_rdata_i  in  line_width  refill line data

## Operation
- **Address split:** offset = low $clog2(line_width/8) bits; set = next $clog2(sets) bits; tag = remainder.
- **Alignment:** offset is truncated to size alignment (low bits ignored).
- **States:** IDLE, LOOKUP, WB, FILL_REQ, FILL_WAIT.
- **IDLE:**
  - req_ready_o=1 only in IDLE.
  - On handshake: request is registered, set arrays are read, next state LOOKUP.
- **LOOKUP:** tag compare across ways.
  - Hit: resp_valid_o=1.
    - Load: rdata_o = selected field.
    - Store: field updated, dirty set; next IDLE.
    - hit_o=1 unless this is a replay.
  - Miss: choose victim, then:
    - victim valid and dirty → WB
    - otherwise → FILL_REQ
- **Victim selection:** lowest-index invalid way; else per-set round-robin pointer (reset 0), advanced by one (mod ways) on each valid-line eviction.
- **WB:** mem_req_valid_o=1, mem_req_write_o=1, mem_addr_o={victim tag, set}, mem_wdata_o=victim data. On handshake → FILL_REQ.
- **FILL_REQ:** mem_req_valid_o=1, write=0, mem_addr_o=request line address. On handshake → FILL_WAIT.
- **FILL_WAIT:** on mem_resp_valid_i, victim way is written with valid=1, dirty=0, new tag and data; next LOOKUP (replay). The replay always hits.
  - Store miss: merged on replay (write-allocate).
  - hit_o=0 on the replay response.
- **Memory-side inputs:** mem_resp_valid_i is ignored outside FILL_WAIT; mem_req_ready_i is ignored when mem_req_valid_o=0.

## Timing
- **Reset values:** req_ready_o=1 (IDLE), resp_valid_o=0, hit_o=0, rdata_o=0, mem_req_valid_o=0, mem_req_write_o=0, mem_addr_o=0, mem_wdata_o=0.
- **Reset effect:** state←IDLE; all valid, dirty and round-robin pointers cleared.
- **Reset mid-operation:**
  - Pending request is dropped with no response.
  - Outstanding mem request is withdrawn.
  - A late mem_resp_valid_i is ignored.
- **Hit latency:** accept in cycle 0, resp_valid_o in cycle 1. Peak throughput is 1 access per 2 cycles.
- **Clean miss:** with mem_req_ready_i=1 and the response one cycle after handshake: FILL_REQ cycle 2, response cycle 3, replay resp_valid_o cycle 4.
- **Dirty miss:** one extra cycle minimum (WB in cycle 2), so resp_valid_o no earlier than cycle 5.
- **Memory handshake:** mem_req_valid_o, mem_req_write_o, mem_addr_o and mem_wdata_o are held stable from assertion until the handshake cycle inclusive.
- **Writeback completion:** a writeback completes on handshake; no response is expected.
- **Single outstanding access:** no new request is accepted until resp_valid_o.

## Configuration
- DCACHE_ASSOC_STATS_EN defined: adds outputs hit_count_o, miss_count_o, wb_count_o (32 bits each, saturating at 0xFFFFFFFF, cleared by rst_i).
  - hit/miss counters increment on each first-lookup outcome (replays not counted).
  - wb_count_o increments on each WB handshake.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- **Cold read miss:** after reset, 32-bit load 0x0010 → refill read at line address 0x0002. Return 0x1122334455667788 → resp_valid_o cycle 4, rdata_o=0x55667788, hit_o=0.
- **Byte store hit:** 8-bit store 0xAB to 0x0013 → resp cycle 1, hit_o=1. Then 64-bit load 0x0010 → 0x11223344AB667788, hit_o=1.
- **Dirty eviction:** then load 0x0090 (way 1), then load 0x0110 (set 2 full).
  - Writeback of way 0 first: mem_addr_o=0x0002, data 0x11223344AB667788.
  - Then refill read at 0x0022.
  - Next eviction in set 2 targets way 1.
- **Backpressure:** mem_req_ready_i low 5 cycles during FILL_REQ → mem_req_valid_o, mem_addr_o stable, req_ready_o=0 throughout; completes after ready rises.
- **Reset mid-refill:** rst_i pulsed in FILL_WAIT, then mem_resp_valid_i pulsed → no resp_valid_o, no array update; a later load of the same address misses.
- **Stats (DCACHE_ASSOC_STATS_EN):** after the sequence above → hit_count_o=2, miss_count_o=3, wb_count_o=1.
